// File: rtl/hdmi_infoframe_pkg.sv
// hdmi_infoframe_pkg: shared InfoFrame constants, types, presets and helpers
package hdmi_infoframe_pkg;
    localparam logic [7:0]  HB0_VSIF  = 8'h81;
    localparam int          PB_COUNT  = 28;
    localparam logic [4:0]  LEN_MIN   = 5'd4;
    localparam logic [23:0] OUI_HF    = 24'hC45DD8;
    localparam logic [23:0] OUI_DOLBY = 24'h00D046;
    localparam logic [4:0]  ALLM_LEN  = 5'd5;
    localparam logic [4:0]  DOLBY_LEN = 5'd27;

    typedef logic [PB_COUNT-1:0][7:0] pb_array_t;
    typedef logic [PB_COUNT-1:1][7:0] pb_body_t;
    typedef enum logic [1:0] {IDLE, CALC, WAIT_FRAME} vsif_state_e;

    function automatic logic [4:0] sat_len(input logic [4:0] l, input logic [4:0] mx);
        return (l < LEN_MIN) ? LEN_MIN : (l > mx) ? mx : l;
    endfunction

    function automatic pb_body_t preset_body(input logic dolby);
        pb_body_t b;
        b = '0;
        b[3:1] = dolby ? OUI_DOLBY : OUI_HF;
        b[5:4] = dolby ? 16'h0003 : 16'h0201;
        return b;
    endfunction
endpackage

// File: rtl/infoframe_checksum_acc.sv
// infoframe_checksum_acc: byte-serial mod-256 accumulator producing the InfoFrame checksum byte
module infoframe_checksum_acc (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic [7:0] seed_i,
    input  logic       add_i,
    input  logic [7:0] data_i,
    output logic [7:0] chk_o
);
    logic [7:0] acc_q;
    // Seed on clear, otherwise fold in one byte per enabled cycle
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) acc_q <= '0;
        else acc_q <= clr_i ? seed_i : add_i ? acc_q + data_i : acc_q;
    assign chk_o = 8'h00 - acc_q;
endmodule

// File: rtl/vsif_packet_gen.sv
// vsif_packet_gen: programmable HDMI VSIF source, tear-free publish on frame_start (option: VSIF_PRESET_EN)
module vsif_packet_gen
    import hdmi_infoframe_pkg::*;
#(
    parameter logic [7:0] VERSION   = 8'h01,
    parameter int         MAX_LEN   = 27,
    parameter int         RESET_LEN = 5
) (
    input  logic             clk_pixel_i,
    input  logic             reset_n_i,
    input  logic             wr_en_i,
    input  logic [4:0]       wr_addr_i,
    input  logic [7:0]       wr_data_i,
    output logic             wr_ready_o,
    input  logic [4:0]       cfg_len_i,
    input  logic [7:0]       cfg_version_i,
    input  logic             commit_i,
    input  logic             frame_start_i,
`ifdef VSIF_PRESET_EN
    input  logic             preset_load_i,
    input  logic [1:0]       preset_sel_i,
`endif
    output logic [23:0]      header_o,
    output logic [3:0][55:0] sub_o,
    output logic             pkt_valid_o,
    output logic             busy_o,
    output logic             update_done_o
);
    vsif_state_e state_q, state_d;
    pb_body_t    shadow_q, shadow_d, stage_q;
    pb_array_t   image_q;
    logic [23:0] header_q;
    logic [4:0]  len_q, len_d, idx_q;
    logic [7:0]  ver_q, pb_b, chk;
    logic        pend_q, valid_q, done_q, go, start, publish, wr_ok;

`ifdef VSIF_PRESET_EN
    logic       preset_go_q, preset_hit;
    logic [4:0] preset_len_q;
    assign preset_hit = preset_load_i && !preset_sel_i[1] && state_q == IDLE && !commit_i;
    assign go         = commit_i || preset_go_q;
    assign len_d      = preset_go_q ? preset_len_q : sat_len(cfg_len_i, 5'(MAX_LEN));
    // A preset loads the shadow one cycle ahead of its implied commit
    always_ff @(posedge clk_pixel_i or negedge reset_n_i)
        if (!reset_n_i) begin
            preset_go_q  <= 1'b0;
            preset_len_q <= ALLM_LEN;
        end else begin
            preset_go_q <= preset_hit;
            if (preset_hit) preset_len_q <= sat_len(preset_sel_i[0] ? DOLBY_LEN : ALLM_LEN, 5'(MAX_LEN));
        end
`else
    assign go    = commit_i;
    assign len_d = sat_len(cfg_len_i, 5'(MAX_LEN));
`endif

    assign wr_ok         = wr_en_i && state_q != CALC && wr_addr_i != 5'd0 && wr_addr_i <= 5'd27;
    assign pb_b          = (idx_q <= len_q) ? shadow_q[idx_q] : 8'h00;
    assign wr_ready_o    = state_q != CALC;
    assign busy_o        = state_q != IDLE;
    assign header_o      = header_q;
    assign sub_o         = image_q;
    assign pkt_valid_o   = valid_q;
    assign update_done_o = done_q;

    infoframe_checksum_acc u_chk (
        .clk_i  (clk_pixel_i),
        .rst_ni (reset_n_i),
        .clr_i  (start),
        .seed_i (HB0_VSIF + cfg_version_i + {3'b000, len_d}),
        .add_i  (state_q == CALC),
        .data_i (pb_b),
        .chk_o  (chk)
    );

    // Shadow bank next state: host writes, or a whole preset image
    always_comb begin
        shadow_d = shadow_q;
        if (wr_ok) shadow_d[wr_addr_i] = wr_data_i;
`ifdef VSIF_PRESET_EN
        if (preset_hit) shadow_d = preset_body(preset_sel_i[0]);
`endif
    end

    // Build sequencing; publish only from WAIT_FRAME, restarting if a commit is outstanding
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        publish = 1'b0;
        case (state_q)
            IDLE:       if (go) begin
                            state_d = CALC;
                            start   = 1'b1;
                        end
            CALC:       if (idx_q == 5'd27) state_d = WAIT_FRAME;
            WAIT_FRAME: if (frame_start_i) begin
                            publish = 1'b1;
                            start   = pend_q || commit_i;
                            state_d = (pend_q || commit_i) ? CALC : IDLE;
                        end
            default:    state_d = IDLE;
        endcase
    end

    // Control state, byte walk over the shadow and staging capture
    always_ff @(posedge clk_pixel_i or negedge reset_n_i)
        if (!reset_n_i) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            shadow_q <= '0;
            stage_q  <= '0;
            len_q    <= 5'(RESET_LEN);
            ver_q    <= VERSION;
            idx_q    <= 5'd1;
        end else begin
            state_q  <= state_d;
            pend_q   <= !publish && (pend_q || (commit_i && state_q != IDLE));
            shadow_q <= shadow_d;
            if (start) begin
                len_q <= len_d;
                ver_q <= cfg_version_i;
                idx_q <= 5'd1;
            end else if (state_q == CALC) begin
                stage_q[idx_q] <= pb_b;
                idx_q          <= idx_q + 5'd1;
            end
        end

    // Active image: changes only on a publish cycle
    always_ff @(posedge clk_pixel_i or negedge reset_n_i)
        if (!reset_n_i) begin
            image_q  <= '0;
            header_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= publish;
            if (publish) begin
                image_q  <= {stage_q, chk};
                header_q <= {3'b000, len_q, ver_q, HB0_VSIF};
                valid_q  <= 1'b1;
            end
        end
endmodule

// File: tb/tb_vsif_packet_gen.sv
// tb_vsif_packet_gen: directed self-checking bench for vsif_packet_gen with a frame-level model
module tb_vsif_packet_gen;
    logic clk = 1'b0, reset_n = 1'b1;
    logic wr_en = 1'b0, commit = 1'b0, frame_start = 1'b0;
    logic [4:0] wr_addr = '0, cfg_len = 5'd5;
    logic [7:0] wr_data = '0, cfg_version = 8'h01;
    logic wr_ready, pkt_valid, busy, update_done;
    logic [23:0] header;
    logic [3:0][55:0] sub;
`ifdef VSIF_PRESET_EN
    logic preset_load = 1'b0;
    logic [1:0] preset_sel = 2'b00;
`endif
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    vsif_packet_gen dut (
        .clk_pixel_i   (clk),
        .reset_n_i     (reset_n),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .wr_ready_o    (wr_ready),
        .cfg_len_i     (cfg_len),
        .cfg_version_i (cfg_version),
        .commit_i      (commit),
        .frame_start_i (frame_start),
`ifdef VSIF_PRESET_EN
        .preset_load_i (preset_load),
        .preset_sel_i  (preset_sel),
`endif
        .header_o      (header),
        .sub_o         (sub),
        .pkt_valid_o   (pkt_valid),
        .busy_o        (busy),
        .update_done_o (update_done)
    );

    // Model: shadow bytes, the image a build would produce, and when that build is ready
    logic [7:0]   m_pb [1:27];
    logic [223:0] m_img, e_img;
    logic [23:0]  m_hdr, e_hdr;
    bit           m_act, m_pend, e_valid, e_done;
    int           cyc, m_ready;

    task automatic chk(input string nm, input logic [223:0] got, input logic [223:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic void build(input int len, input logic [7:0] ver);
        int s = 'h81 + int'(ver) + len;
        m_img = '0;
        for (int i = 1; i <= 27; i++)
            if (i <= len) begin
                m_img[8*i +: 8] = m_pb[i];
                s += int'(m_pb[i]);
            end
        m_img[7:0] = 8'((256 - s % 256) % 256);
        m_hdr = {3'b000, 5'(len), ver, 8'h81};
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            foreach (m_pb[i]) m_pb[i] = 8'h00;
            m_act = 0; m_pend = 0; e_valid = 0; e_done = 0;
            e_img = '0; e_hdr = '0; cyc = 0; m_ready = 0;
        end else begin : step
            bit calc, start;
            int len;
            calc = m_act && cyc < m_ready;
            e_done = 1'b0;
            start = 1'b0;
            if (m_act && !calc && frame_start) begin
                e_img = m_img; e_hdr = m_hdr; e_valid = 1'b1; e_done = 1'b1;
                start = m_pend || commit;
                m_pend = 1'b0;
                m_act = start;
            end else if (commit) begin
                if (m_act) m_pend = 1'b1;
                else start = 1'b1;
            end
            if (wr_en && !calc && wr_addr >= 5'd1 && wr_addr <= 5'd27) m_pb[wr_addr] = wr_data;
            if (start) begin
                len = (cfg_len < 5'd4) ? 4 : (cfg_len > 5'd27) ? 27 : int'(cfg_len);
                build(len, cfg_version);
                m_act = 1'b1;
                m_ready = cyc + 28;
            end
            cyc++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            chk("header", 224'(header), 224'(e_hdr));
            chk("sub", 224'(sub), e_img);
            chk("pkt_valid", 224'(pkt_valid), 224'(e_valid));
            chk("update_done", 224'(update_done), 224'(e_done));
            chk("busy", 224'(busy), 224'(m_act));
            chk("wr_ready", 224'(wr_ready), 224'(!(m_act && cyc < m_ready)));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic cmt(input logic [4:0] l, input logic [7:0] v);
        cfg_len = l; cfg_version = v; commit = 1'b1;
        tick(1);
        commit = 1'b0;
    endtask

    task automatic frm();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [223:0] snap;
        #1 reset_n = 1'b0;
        tick(2);
        chk("rst_header", 224'(header), 224'(0));
        chk("rst_sub", 224'(sub), 224'(0));
        chk("rst_valid", 224'(pkt_valid), 224'(0));
        reset_n = 1'b1;
        tick(1);

        wr(1, 8'hD8); wr(2, 8'h5D); wr(3, 8'hC4); wr(4, 8'h01); wr(5, 8'h02);
        cmt(5, 8'h01);
        tick(30);
        frm();
        chk("allm_header", 224'(header), 224'(24'h050181));
        chk("allm_model_hdr", 224'(e_hdr), 224'(24'h050181));
        chk("allm_sub0", 224'(sub[0]), 224'(56'h02_01_C4_5D_D8_7D));
        chk("allm_sub321", 224'(sub[3:1]), 224'(0));
        chk("allm_done", 224'(update_done), 224'(1));
        chk("allm_valid", 224'(pkt_valid), 224'(1));
        tick(1);
        chk("allm_done_once", 224'(update_done), 224'(0));

        wr(9, 8'hAA);
        cmt(5, 8'h01);
        tick(30);
        frm();
        chk("mask_pb9", 224'(sub[1][23:16]), 224'(0));
        chk("mask_pb0", 224'(sub[0][7:0]), 224'(8'h7D));

        wr(1, 8'h46); wr(2, 8'hD0); wr(3, 8'h00); wr(4, 8'h03); wr(5, 8'h00); wr(9, 8'h00);
        cmt(27, 8'h01);
        tick(30);
        frm();
        chk("dolby_pb0", 224'(sub[0][7:0]), 224'(8'h4A));
        chk("dolby_header", 224'(header), 224'(24'h1B0181));

        wr(1, 8'hD8); wr(2, 8'h33); wr(3, 8'hC4); wr(4, 8'h01); wr(5, 8'h02);
        snap = sub;
        cmt(5, 8'h01);
        tick(9);
        frm();
        tick(5);
        chk("tear_sub", 224'(sub), snap);
        chk("tear_header", 224'(header), 224'(24'h1B0181));
        tick(20);
        frm();
        chk("tear_pub_header", 224'(header), 224'(24'h050181));
        chk("tear_pub_sub0", 224'(sub[0]), 224'(56'h02_01_C4_33_D8_A7));

        cmt(5, 8'h01);
        tick(3);
        wr(5, 8'h55);
        cmt(5, 8'h01);
        cmt(5, 8'h01);
        tick(30);
        frm();
        chk("pend_first", 224'(sub[0]), 224'(56'h02_01_C4_33_D8_A7));
        chk("pend_busy", 224'(busy), 224'(1));
        tick(30);
        frm();
        chk("pend_second", 224'(sub[0]), 224'(56'h02_01_C4_33_D8_A7));
        chk("pend_idle", 224'(busy), 224'(0));

        wr(5, 8'h07);
        cmt(5, 8'h01);
        tick(30);
        wr(5, 8'h09);
        cmt(5, 8'h01);
        tick(2);
        frm();
        chk("pend_old_pb5", 224'(sub[0][47:40]), 224'(8'h07));
        tick(30);
        frm();
        chk("pend_new_pb5", 224'(sub[0][47:40]), 224'(8'h09));

        cmt(5, 8'h01);
        tick(30);
        commit = 1'b1; frame_start = 1'b1;
        tick(1);
        commit = 1'b0; frame_start = 1'b0;
        chk("both_done", 224'(update_done), 224'(1));
        chk("both_busy", 224'(busy), 224'(1));
        tick(30);
        frm();
        chk("both_second", 224'(update_done), 224'(1));

        cmt(5, 8'h01);
        tick(30);
        reset_n = 1'b0;
        #1;
        chk("arst_header", 224'(header), 224'(0));
        chk("arst_sub", 224'(sub), 224'(0));
        chk("arst_valid", 224'(pkt_valid), 224'(0));
        chk("arst_busy", 224'(busy), 224'(0));
        chk("arst_done", 224'(update_done), 224'(0));
        tick(2);
        reset_n = 1'b1;
        tick(1);

        cmt(2, 8'h01);
        tick(30);
        frm();
        chk("sat_lo_header", 224'(header), 224'(24'h040181));
        chk("sat_lo_pb0", 224'(sub[0][7:0]), 224'(8'h7A));
        cmt(31, 8'h02);
        tick(30);
        frm();
        chk("sat_hi_header", 224'(header), 224'(24'h1B0281));
        chk("sat_hi_pb0", 224'(sub[0][7:0]), 224'(8'h62));
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
